pwm_cfg_sched: RTL and testbench
================================

# pwm_cfg_sched

Configuration scheduler for the PWM generator. Arbitrates round-robin among several requesters that want to change the PWM duty (`d`) and period (`w`) settings. Stages the winning request in a shadow register and commits it to the PWM datapath only on a period boundary, so the output never carries a truncated or glitched pulse. Enforces a minimum of one full PWM period per committed configuration.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (2..8).
- `DW`, 4: width of the `d` and `w` settings.
- `IDW`, 2: width of requester index, `$clog2(NUM_REQ)`.

Ports:
- `clk`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_d`  in  NUM_REQ*DW  requested duty. Requester i uses bits [i*DW +: DW].
- `req_w`  in  NUM_REQ*DW  requested period, packed the same way.
- `req_ready`  out  NUM_REQ  one-hot accept. Combinational.
- `period_end`  in  1  one-cycle pulse from the PWM datapath on the last cycle of each PWM period.
- `d`  out  DW  duty applied to the PWM datapath. Registered.
- `w`  out  DW  period applied to the PWM datapath. Registered.
- `applied`  out  1  one-cycle pulse on the cycle `d`/`w` change.
- `applied_id`  out  IDW  requester whose config was committed. Held until the next commit.
- `busy`  out  1  high when state is not IDLE.

## Operation
- Handshake: valid/ready.
  - A transfer occurs on a rising edge where `req_valid[i] && req_ready[i]`.
  - A requester holds valid and data stable until accepted.
  - Dropping valid before acceptance is legal and cancels the request with no side effect.
- Arbitration:
  - Round-robin with pointer `rr_ptr`. Priority order is `rr_ptr`, `rr_ptr+1`, … mod NUM_REQ.
  - After accepting requester i, `rr_ptr` becomes (i+1) mod NUM_REQ.
  - `rr_ptr` does not change when nothing is accepted.
- `req_ready` is nonzero only in IDLE. It is the one-hot grant of the highest-priority asserted valid.
- FSM, 2-bit:
  - IDLE:
    - On accept, capture `req_d`/`req_w` of the winner into `sh_d`/`sh_w`, capture its index into `sh_id`, then go to PEND.
    - `period_end` in IDLE is ignored.
  - PEND:
    - On `period_end`, load `d<=sh_d`, `w<=sh_w`, `applied_id<=sh_id`, `applied<=1`, then go to HOLD.
    - With no `period_end`, stay in PEND.
  - HOLD:
    - On `period_end`, go to IDLE. This guarantees at least one complete period at the new setting.
    - All `req_ready` are 0 in HOLD.
- Simultaneous events:
  - Accept and `period_end` in the same IDLE cycle: the accept proceeds to PEND, and that `period_end` is not used for the commit. The commit waits for the next `period_end`.
  - `period_end` on the first cycle of PEND (the cycle after accept) commits normally.
- Values are passed through unmodified. `d`=0 or `w`=0 are legal settings; their interpretation belongs to the datapath.
- Reset mid-operation: all state is discarded immediately.
  - A pending shadow config is lost. Its requester must re-request.
  - `d`/`w` return to 0.

## Timing
- Reset values:
  - `d`=0, `w`=0, `applied`=0, `applied_id`=0, `busy`=0, `req_ready`=0.
  - Internal: state=IDLE, `rr_ptr`=0, shadow registers=0.
- `req_ready` is combinational from `req_valid`, `rr_ptr` and state. There is no registered latency to grant.
- Commit latency: `d`/`w` update on the rising edge that samples the first `period_end` strictly after the accept edge. Minimum is 1 cycle after accept.
- `applied` is high for exactly the one cycle following the commit edge.
- Minimum spacing between consecutive accepts is two `period_end` pulses: one to commit, one to complete HOLD.
- `busy` is registered and equals (state != IDLE).

## Structure
- Shared package `pwm_pkg`:
  - FSM state localparams `ST_IDLE`, `ST_PEND`, `ST_HOLD`.
  - Default `DW`.
  - The packed-field index helper used by the PWM blocks.
- Sub-module `rr_arbiter`:
  - Parameterized by NUM_REQ.
  - Inputs: request vector, `rr_ptr`, enable.
  - Outputs: one-hot grant and binary index.
  - Reused by any other shared-resource block in the PWM subsystem.
- The top level holds the FSM, shadow registers, output registers and pointer update.

## Test plan
- Reset:
  - Stimulus: assert `reset`=0 mid-PEND with `sh_d`=5.
  - Required: `d`=`w`=0, `busy`=0, `req_ready`=0 immediately (async). After release, no `applied` pulse on subsequent `period_end`.
- Single request:
  - Stimulus: requester 1 sends d=4, w=4; `period_end` arrives 3 cycles later.
  - Required: `req_ready`=4'b0010 for one cycle. `d`=4, `w`=4 and `applied`=1 on the cycle after `period_end`, with `applied_id`=1. `busy` drops after the next `period_end`.
- Contention:
  - Stimulus: all four valid continuously, with `period_end` every 16 cycles.
  - Required: accept order 0,1,2,3,0. Each config stays on `d`/`w` for at least 16 cycles.
- Simultaneous events:
  - Stimulus: accept (d=1, w=15) on the same edge as `period_end`.
  - Required: no commit on that `period_end`. Commit on the next `period_end`.
- Withdrawn request:
  - Stimulus: requester 2 raises valid during HOLD and drops it before IDLE.
  - Required: no accept and `rr_ptr` unchanged. The next request from requester 0 is granted per pointer order.
- Boundary values:
  - Stimulus: d=15, w=1, then d=0, w=0.
  - Required: both committed verbatim. `applied` pulses twice, separated by at least 2 `period_end` pulses.

Source files
------------

// File: rtl/pwm_pkg.sv
// ============================================================================
// pwm_pkg : shared types, defaults and helpers for the PWM subsystem
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package pwm_pkg;

   localparam int PWM_DW = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PEND = 2'd1,
      ST_HOLD = 2'd2
   } state_e;

   // LSB position of field idx inside a packed vector of width-bit fields
   function automatic int fld_lsb(input int idx, input int width);
      return idx * width;
   endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// rr_arbiter : round-robin arbiter, priority starts at ptr and wraps upward
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDW     = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDW-1:0]     ptr,
   input  logic               en,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDW-1:0]     idx
);

   int   w_pos;
   logic w_found;

   always_comb begin
      gnt     = '0;
      idx     = '0;
      w_pos   = 0;
      w_found = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_pos = int'(ptr) + k;
         if (w_pos >= NUM_REQ) w_pos = w_pos - NUM_REQ;
         if (en && !w_found && req[w_pos]) begin
            gnt[w_pos] = 1'b1;
            idx        = IDW'(w_pos);
            w_found    = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/pwm_cfg_sched.sv
// ============================================================================
// pwm_cfg_sched : arbitrates PWM config requests and commits on period ends
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module pwm_cfg_sched
   import pwm_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int DW      = PWM_DW,
   parameter int IDW     = $clog2(NUM_REQ)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [NUM_REQ*DW-1:0] req_d,
   input  logic [NUM_REQ*DW-1:0] req_w,
   output logic [NUM_REQ-1:0]    req_ready,
   input  logic                  period_end,
   output logic [DW-1:0]         d,
   output logic [DW-1:0]         w,
   output logic                  applied,
   output logic [IDW-1:0]        applied_id,
   output logic                  busy
);

   state_e               r_state;
   state_e               w_nxt;
   logic [IDW-1:0]       r_rr_ptr;
   logic [DW-1:0]        r_sh_d;
   logic [DW-1:0]        r_sh_w;
   logic [IDW-1:0]       r_sh_id;
   logic [NUM_REQ-1:0]   w_gnt;
   logic [IDW-1:0]       w_idx;
   logic                 w_accept;
   logic                 w_commit;
   logic [IDW-1:0]       w_ptr_nxt;
   logic [DW-1:0]        w_win_d;
   logic [DW-1:0]        w_win_w;

   // Grants are suppressed while reset is asserted so req_ready reads 0
   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDW     (IDW)
   ) u_arb (
      .req (req_valid),
      .ptr (r_rr_ptr),
      .en  ((r_state == ST_IDLE) && reset),
      .gnt (w_gnt),
      .idx (w_idx)
   );

   assign req_ready = w_gnt;
   assign w_accept  = |(w_gnt & req_valid);
   assign w_commit  = (r_state == ST_PEND) && period_end;
   assign w_ptr_nxt = (w_idx == IDW'(NUM_REQ - 1)) ? '0 : w_idx + IDW'(1);
   assign w_win_d   = req_d[fld_lsb(int'(w_idx), DW) +: DW];
   assign w_win_w   = req_w[fld_lsb(int'(w_idx), DW) +: DW];

   always_comb begin
      w_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_accept)   w_nxt = ST_PEND;
         ST_PEND: if (period_end) w_nxt = ST_HOLD;
         ST_HOLD: if (period_end) w_nxt = ST_IDLE;
         default:                 w_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= ST_IDLE;
         r_rr_ptr   <= '0;
         r_sh_d     <= '0;
         r_sh_w     <= '0;
         r_sh_id    <= '0;
         d          <= '0;
         w          <= '0;
         applied    <= 1'b0;
         applied_id <= '0;
         busy       <= 1'b0;
      end else begin
         r_state <= w_nxt;
         busy    <= (w_nxt != ST_IDLE);
         applied <= w_commit;
         if (w_accept) begin
            r_sh_d   <= w_win_d;
            r_sh_w   <= w_win_w;
            r_sh_id  <= w_idx;
            r_rr_ptr <= w_ptr_nxt;
         end
         if (w_commit) begin
            d          <= r_sh_d;
            w          <= r_sh_w;
            applied_id <= r_sh_id;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_pwm_cfg_sched.sv
// ============================================================================
// tb_pwm_cfg_sched : scoreboard bench for pwm_cfg_sched, directed vectors
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_pwm_cfg_sched;

   localparam int NUM_REQ = 4;
   localparam int DW      = 4;
   localparam int IDW     = 2;

   logic                  clk = 1'b0;
   logic                  reset = 1'b0;
   logic [NUM_REQ-1:0]    req_valid = '0;
   logic [NUM_REQ*DW-1:0] req_d = '0;
   logic [NUM_REQ*DW-1:0] req_w = '0;
   logic                  period_end = 1'b0;
   logic [NUM_REQ-1:0]    req_ready;
   logic [DW-1:0]         d;
   logic [DW-1:0]         w;
   logic                  applied;
   logic [IDW-1:0]        applied_id;
   logic                  busy;

   pwm_cfg_sched #(.NUM_REQ(NUM_REQ), .DW(DW), .IDW(IDW)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_d      (req_d),
      .req_w      (req_w),
      .req_ready  (req_ready),
      .period_end (period_end),
      .d          (d),
      .w          (w),
      .applied    (applied),
      .applied_id (applied_id),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [IDW-1:0] id;
      logic [DW-1:0]  d;
      logic [DW-1:0]  w;
   } cfg_t;

   cfg_t exp_cfg_q[$];
   int   exp_acc_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [DW-1:0] dv, input logic [DW-1:0] wv);
      req_d[i*DW +: DW] = dv;
      req_w[i*DW +: DW] = wv;
   endtask

   task automatic expect_txn(input int id, input logic [DW-1:0] dv, input logic [DW-1:0] wv);
      cfg_t e;
      e.id = IDW'(id);
      e.d  = dv;
      e.w  = wv;
      exp_acc_q.push_back(id);
      exp_cfg_q.push_back(e);
   endtask

   // Drive period_end every per cycles; each requester drops valid once accepted
   task automatic run_drain(input int per, input int maxc);
      logic [NUM_REQ-1:0] acc;
      for (int c = 0; c < maxc; c++) begin
         if (req_valid == '0 && !busy) break;
         period_end = (c % per == per - 1);
         #1;
         acc = req_valid & req_ready;
         cyc();
         req_valid = req_valid & ~acc;
      end
      period_end = 1'b0;
      chk("drain_done", {31'd0, (req_valid == '0 && !busy)}, 32'd1);
   endtask

   // Scoreboard monitor: sampled mid-cycle on the falling edge
   int   pe_since = 0;
   bit   have_prev = 1'b0;
   int   m_gi;
   cfg_t m_e;

   always @(negedge clk) begin
      if (!reset) begin
         pe_since  = 0;
         have_prev = 1'b0;
      end else begin
         if (|(req_valid & req_ready)) begin
            m_gi = 0;
            for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) m_gi = i;
            chk("ready_onehot", {31'd0, $onehot(req_ready)}, 32'd1);
            if (exp_acc_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL accept: unexpected accept of requester %0d, expected none", m_gi);
            end else begin
               chk("accept_id", m_gi, exp_acc_q.pop_front());
            end
         end
         if (applied) begin
            if (exp_cfg_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL applied: unexpected commit id=%0d d=%0d w=%0d, expected none",
                        applied_id, d, w);
            end else begin
               m_e = exp_cfg_q.pop_front();
               chk("applied_id", {30'd0, applied_id}, {30'd0, m_e.id});
               chk("applied_d", {28'd0, d}, {28'd0, m_e.d});
               chk("applied_w", {28'd0, w}, {28'd0, m_e.w});
            end
            if (have_prev) chk("applied_spacing_ge2", {31'd0, (pe_since >= 2)}, 32'd1);
            have_prev = 1'b1;
            pe_since  = 0;
         end
         if (period_end) pe_since++;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   int n_app;
   int last_app;

   initial begin
      // Reset state, with valids asserted to confirm no grant during reset
      req_valid = 4'hF;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_d", {28'd0, d}, 32'd0);
      chk("rst_w", {28'd0, w}, 32'd0);
      chk("rst_applied", {31'd0, applied}, 32'd0);
      chk("rst_applied_id", {30'd0, applied_id}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_ready", {28'd0, req_ready}, 32'd0);
      req_valid = '0;
      reset = 1'b1;
      cyc();

      // Contention: all four valid, period_end every 16 cycles
      for (int i = 0; i < NUM_REQ; i++) set_req(i, DW'(i + 1), DW'(i + 8));
      expect_txn(0, 4'd1, 4'd8);
      expect_txn(1, 4'd2, 4'd9);
      expect_txn(2, 4'd3, 4'd10);
      expect_txn(3, 4'd4, 4'd11);
      expect_txn(0, 4'd1, 4'd8);
      req_valid = 4'hF;
      n_app = 0;
      last_app = 0;
      for (int c = 0; c < 200; c++) begin
         if (n_app == 5 && !busy) break;
         period_end = (c % 16 == 15);
         cyc();
         if (applied) begin
            if (n_app > 0) chk("contention_hold_ge16", {31'd0, (c - last_app >= 16)}, 32'd1);
            n_app++;
            last_app = c;
            if (n_app == 5) req_valid = '0;
         end
      end
      period_end = 1'b0;
      chk("contention_commits", n_app, 32'd5);
      chk("contention_final_d", {28'd0, d}, 32'd1);

      // Reset while PEND holds a shadow config with d=5
      set_req(1, 4'd5, 4'd7);
      req_valid = 4'b0010;
      exp_acc_q.push_back(1);
      cyc();
      req_valid = '0;
      cyc();
      chk("pend_busy", {31'd0, busy}, 32'd1);
      #2;
      reset = 1'b0;
      req_valid = 4'b0001;
      #1;
      chk("async_rst_d", {28'd0, d}, 32'd0);
      chk("async_rst_w", {28'd0, w}, 32'd0);
      chk("async_rst_busy", {31'd0, busy}, 32'd0);
      chk("async_rst_ready", {28'd0, req_ready}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      req_valid = '0;
      for (int k = 0; k < 12; k++) begin
         period_end = (k % 4 == 3);
         cyc();
         chk("post_rst_no_applied", {31'd0, applied}, 32'd0);
      end
      period_end = 1'b0;

      // Single request from requester 1, period_end 3 cycles after accept
      set_req(1, 4'd4, 4'd4);
      req_valid = 4'b0010;
      #1;
      chk("single_ready", {28'd0, req_ready}, 32'd2);
      expect_txn(1, 4'd4, 4'd4);
      cyc();
      req_valid = '0;
      #1;
      chk("single_ready_after", {28'd0, req_ready}, 32'd0);
      chk("single_busy", {31'd0, busy}, 32'd1);
      cyc();
      cyc();
      chk("single_no_early_commit", {28'd0, d}, 32'd0);
      period_end = 1'b1;
      cyc();
      period_end = 1'b0;
      chk("single_applied", {31'd0, applied}, 32'd1);
      chk("single_d", {28'd0, d}, 32'd4);
      chk("single_w", {28'd0, w}, 32'd4);
      chk("single_id", {30'd0, applied_id}, 32'd1);
      cyc();
      chk("single_applied_pulse", {31'd0, applied}, 32'd0);
      repeat (3) cyc();
      chk("single_hold_busy", {31'd0, busy}, 32'd1);
      period_end = 1'b1;
      cyc();
      period_end = 1'b0;
      chk("single_idle", {31'd0, busy}, 32'd0);

      // Accept on the same edge as period_end: commit waits for the next one
      set_req(3, 4'd1, 4'd15);
      req_valid = 4'b1000;
      period_end = 1'b1;
      expect_txn(3, 4'd1, 4'd15);
      cyc();
      req_valid = '0;
      period_end = 1'b0;
      chk("simul_busy", {31'd0, busy}, 32'd1);
      cyc();
      chk("simul_no_commit", {31'd0, applied}, 32'd0);
      chk("simul_d_unchanged", {28'd0, d}, 32'd4);
      cyc();
      period_end = 1'b1;
      cyc();
      period_end = 1'b0;
      chk("simul_applied", {31'd0, applied}, 32'd1);
      chk("simul_d", {28'd0, d}, 32'd1);
      chk("simul_w", {28'd0, w}, 32'd15);
      period_end = 1'b1;
      cyc();
      period_end = 1'b0;

      // Commit on the first PEND cycle, then a withdrawn request during HOLD
      set_req(0, 4'd2, 4'd3);
      req_valid = 4'b0001;
      expect_txn(0, 4'd2, 4'd3);
      cyc();
      req_valid = '0;
      period_end = 1'b1;
      cyc();
      period_end = 1'b0;
      chk("first_pend_commit", {31'd0, applied}, 32'd1);
      chk("first_pend_d", {28'd0, d}, 32'd2);
      set_req(2, 4'd9, 4'd6);
      req_valid = 4'b0100;
      #1;
      chk("hold_ready", {28'd0, req_ready}, 32'd0);
      repeat (3) cyc();
      req_valid = '0;
      period_end = 1'b1;
      cyc();
      period_end = 1'b0;
      chk("withdraw_idle", {31'd0, busy}, 32'd0);
      set_req(0, 4'd6, 4'd9);
      req_valid = 4'b0101;
      #1;
      chk("ptr_order_ready", {28'd0, req_ready}, 32'd4);
      expect_txn(2, 4'd9, 4'd6);
      expect_txn(0, 4'd6, 4'd9);
      run_drain(4, 100);

      // Boundary values passed through verbatim
      set_req(1, 4'd15, 4'd1);
      req_valid = 4'b0010;
      expect_txn(1, 4'd15, 4'd1);
      run_drain(3, 60);
      chk("bound_d15", {28'd0, d}, 32'd15);
      chk("bound_w1", {28'd0, w}, 32'd1);
      set_req(1, 4'd0, 4'd0);
      req_valid = 4'b0010;
      expect_txn(1, 4'd0, 4'd0);
      run_drain(3, 60);
      chk("bound_d0", {28'd0, d}, 32'd0);
      chk("bound_w0", {28'd0, w}, 32'd0);

      repeat (2) cyc();
      chk("acc_queue_empty", exp_acc_q.size(), 32'd0);
      chk("cfg_queue_empty", exp_cfg_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
